// File: rtl/mul4_eval_pkg.sv
// Shared types, constants and helpers for the bit-sliced 2x2 multiplier fitness sequencer.
// The golden model and LFSR step live here so every stage sees one definition.
`timescale 1ns/1ps
package mul4_eval_pkg;

    localparam int PLANE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_ACCUM   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Round 0: every (A,B) pair of 2-bit operands appears in exactly one lane.
    localparam logic [PLANE_W-1:0] R0_A1 = 16'hFF00;
    localparam logic [PLANE_W-1:0] R0_A0 = 16'hF0F0;
    localparam logic [PLANE_W-1:0] R0_B1 = 16'hCCCC;
    localparam logic [PLANE_W-1:0] R0_B0 = 16'hAAAA;

    localparam logic [31:0] LFSR_INIT = 32'h0000_0001;
    localparam int LFSR_TAP3 = 31;
    localparam int LFSR_TAP2 = 21;
    localparam int LFSR_TAP1 = 1;
    localparam int LFSR_TAP0 = 0;

    localparam logic [PLANE_W-1:0] B1_MASK = 16'h5A5A;
    localparam logic [PLANE_W-1:0] B0_MASK = 16'hA5A5;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[LFSR_TAP3] ^ s[LFSR_TAP2] ^ s[LFSR_TAP1] ^ s[LFSR_TAP0]};
    endfunction

    // Returns {p3, p2, p1, p0}, one plane per product bit.
    function automatic logic [4*PLANE_W-1:0] mul2x2_golden(
        input logic [PLANE_W-1:0] a1,
        input logic [PLANE_W-1:0] a0,
        input logic [PLANE_W-1:0] b1,
        input logic [PLANE_W-1:0] b0
    );
        logic [PLANE_W-1:0] p3;
        logic [PLANE_W-1:0] p2;
        logic [PLANE_W-1:0] p1;
        logic [PLANE_W-1:0] p0;
        p0 = a0 & b0;
        p1 = (a1 & b0) ^ (a0 & b1);
        p2 = a1 & b1 & ~(a0 & b0);
        p3 = a1 & a0 & b1 & b0;
        return {p3, p2, p1, p0};
    endfunction

endpackage

// File: rtl/mul4_fitness_sequencer_popcount.sv
// Combinational population count: nibble counts first, then a sum over the nibbles.
`timescale 1ns/1ps
module plane_popcount #(
    parameter int N     = 64,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     bits,
    output logic [CNT_W-1:0] count
);
    localparam int NIB = N / 4;

    logic [2:0] nib_cnt_s [NIB];

    // First level: count ones within each 4-bit group.
    always_comb begin
        for (int i = 0; i < NIB; i++) begin
            nib_cnt_s[i] = 3'(bits[4*i]) + 3'(bits[4*i+1]) + 3'(bits[4*i+2]) + 3'(bits[4*i+3]);
        end
    end

    // Second level: sum the group counts.
    always_comb begin
        count = {CNT_W{1'b0}};
        for (int i = 0; i < NIB; i++) begin
            count = count + CNT_W'(nib_cnt_s[i]);
        end
    end

endmodule

// File: rtl/mul4_fitness_sequencer.sv
// Drives operand planes into a combinational 2x2 multiplier candidate, captures its
// product planes and accumulates the number of bits that agree with the golden product.
`timescale 1ns/1ps
module mul4_fitness_sequencer
    import mul4_eval_pkg::*;
#(
    parameter  int LANES   = PLANE_W,
    parameter  int ROUNDS  = 8,
    localparam int SCORE_W = $clog2(ROUNDS * 4 * LANES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        seed,
    output logic [LANES-1:0]   a1,
    output logic [LANES-1:0]   a0,
    output logic [LANES-1:0]   b1,
    output logic [LANES-1:0]   b0,
    input  logic [LANES-1:0]   y3,
    input  logic [LANES-1:0]   y2,
    input  logic [LANES-1:0]   y1,
    input  logic [LANES-1:0]   y0,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] score
);
    localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int BITS  = 4 * LANES;
    localparam int CNT_W = $clog2(BITS + 1);

    state_e             state_r;
    logic [31:0]        lfsr_r;
    logic [RND_W-1:0]   round_r;
    logic [LANES-1:0]   a1_r;
    logic [LANES-1:0]   a0_r;
    logic [LANES-1:0]   b1_r;
    logic [LANES-1:0]   b0_r;
    logic [BITS-1:0]    cap_y_r;
    logic [LANES-1:0]   cap_a1_r;
    logic [LANES-1:0]   cap_a0_r;
    logic [LANES-1:0]   cap_b1_r;
    logic [LANES-1:0]   cap_b0_r;
    logic [SCORE_W-1:0] score_r;
    logic               busy_r;
    logic               done_r;

    logic [31:0]        lfsr_next_s;
    logic [31:0]        seed_load_s;
    logic [BITS-1:0]    golden_s;
    logic [BITS-1:0]    match_s;
    logic [CNT_W-1:0]   match_cnt_s;
    logic               last_round_s;

    // Next-state helpers for the LFSR, the seed load and the compare stage.
    always_comb begin
        lfsr_next_s  = lfsr_step(lfsr_r);
        seed_load_s  = (seed == 32'h0000_0000) ? LFSR_INIT : seed;
        golden_s     = mul2x2_golden(cap_a1_r, cap_a0_r, cap_b1_r, cap_b0_r);
        match_s      = ~(cap_y_r ^ golden_s);
        last_round_s = (round_r == RND_W'(ROUNDS - 1));
    end

    plane_popcount #(
        .N     (BITS),
        .CNT_W (CNT_W)
    ) u_popcount (
        .bits  (match_s),
        .count (match_cnt_s)
    );

    // Evaluation FSM with all outputs registered; abort preempts every active-state move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            lfsr_r   <= LFSR_INIT;
            round_r  <= {RND_W{1'b0}};
            a1_r     <= {LANES{1'b0}};
            a0_r     <= {LANES{1'b0}};
            b1_r     <= {LANES{1'b0}};
            b0_r     <= {LANES{1'b0}};
            cap_y_r  <= {BITS{1'b0}};
            cap_a1_r <= {LANES{1'b0}};
            cap_a0_r <= {LANES{1'b0}};
            cap_b1_r <= {LANES{1'b0}};
            cap_b0_r <= {LANES{1'b0}};
            score_r  <= {SCORE_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        lfsr_r  <= seed_load_s;
                        score_r <= {SCORE_W{1'b0}};
                        round_r <= {RND_W{1'b0}};
                        a1_r    <= R0_A1;
                        a0_r    <= R0_A0;
                        b1_r    <= R0_B1;
                        b0_r    <= R0_B0;
                        busy_r  <= 1'b1;
                        state_r <= ST_DRIVE;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (abort) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cap_y_r  <= {y3, y2, y1, y0};
                        cap_a1_r <= a1_r;
                        cap_a0_r <= a0_r;
                        cap_b1_r <= b1_r;
                        cap_b0_r <= b0_r;
                        state_r  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (abort) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        score_r <= score_r + SCORE_W'(match_cnt_s);
                        lfsr_r  <= lfsr_next_s;
                        round_r <= round_r + RND_W'(1);
                        a1_r    <= lfsr_next_s[31:16];
                        a0_r    <= lfsr_next_s[15:0];
                        b1_r    <= lfsr_next_s[15:0] ^ B1_MASK;
                        b0_r    <= lfsr_next_s[31:16] ^ B0_MASK;
                        if (last_round_s) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_DRIVE;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign a1    = a1_r;
    assign a0    = a0_r;
    assign b1    = b1_r;
    assign b0    = b0_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign score = score_r;

endmodule

// File: tb/tb_mul4_fitness_sequencer.sv
// Scoreboard bench: two sequencers (1 and 8 rounds) driving arithmetic multiplier candidates.
`timescale 1ns/1ps
module tb_mul4_fitness_sequencer;

    typedef struct {
        int score;
        int due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          mode;
    logic [63:0] emask;
    exp_t        q1[$];
    exp_t        q8[$];

    logic        start1, abort1, busy1, done1;
    logic [31:0] seed1;
    logic [15:0] a1_1, a0_1, b1_1, b0_1, y3_1, y2_1, y1_1, y0_1;
    logic [6:0]  score1;

    logic        start8, abort8, busy8, done8;
    logic [31:0] seed8;
    logic [15:0] a1_8, a0_8, b1_8, b0_8, y3_8, y2_8, y1_8, y0_8;
    logic [9:0]  score8;

    // Candidate: per lane A*B with plain arithmetic, optionally corrupted by mode.
    function automatic logic [63:0] cand(input logic [15:0] a1, input logic [15:0] a0,
                                         input logic [15:0] b1, input logic [15:0] b0,
                                         input int m, input logic [63:0] mk);
        logic [63:0] t;
        int av, bv, p;
        t = 64'h0;
        for (int i = 0; i < 16; i++) begin
            av = 2 * int'(a1[i]) + int'(a0[i]);
            bv = 2 * int'(b1[i]) + int'(b0[i]);
            p  = av * bv;
            t[i]      = p[0];
            t[16 + i] = p[1];
            t[32 + i] = p[2];
            t[48 + i] = p[3];
        end
        case (m)
            1:       t = 64'h0;
            2:       t = {64{1'b1}};
            3:       t = t ^ mk;
            default: t = t;
        endcase
        return t;
    endfunction

    // Reference: regenerate the operand sequence and count agreeing product bits.
    function automatic int model_score(input logic [31:0] s, input int rounds,
                                       input int m, input logic [63:0] mk);
        logic [31:0] l;
        logic [15:0] a1, a0, b1, b0;
        int tot;
        tot = 0;
        l = (s == 32'h0) ? 32'h1 : s;
        for (int r = 0; r < rounds; r++) begin
            if (r == 0) begin
                a1 = 16'hFF00; a0 = 16'hF0F0; b1 = 16'hCCCC; b0 = 16'hAAAA;
            end else begin
                l  = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
                a1 = l[31:16];
                a0 = l[15:0];
                b1 = l[15:0] ^ 16'h5A5A;
                b0 = l[31:16] ^ 16'hA5A5;
            end
            tot += $countones(~(cand(a1, a0, b1, b0, m, mk) ^ cand(a1, a0, b1, b0, 0, 64'h0)));
        end
        return tot;
    endfunction

    assign {y3_1, y2_1, y1_1, y0_1} = cand(a1_1, a0_1, b1_1, b0_1, mode, emask);
    assign {y3_8, y2_8, y1_8, y0_8} = cand(a1_8, a0_8, b1_8, b0_8, mode, emask);

    mul4_fitness_sequencer #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .seed(seed1),
        .a1(a1_1), .a0(a0_1), .b1(b1_1), .b0(b0_1),
        .y3(y3_1), .y2(y2_1), .y1(y1_1), .y0(y0_1),
        .busy(busy1), .done(done1), .score(score1)
    );

    mul4_fitness_sequencer #(.ROUNDS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8), .seed(seed8),
        .a1(a1_8), .a0(a0_8), .b1(b1_8), .b0(b0_8),
        .y3(y3_8), .y2(y2_8), .y1(y1_8), .y0(y0_8),
        .busy(busy8), .done(done8), .score(score8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (done1 === 1'b1) begin
                if (q1.size() == 0) begin
                    check("done1_unexpected", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("score1", longint'(score1), longint'(e.score));
                    check("done1_cycle", longint'(cyc), longint'(e.due));
                end
            end
            if (done8 === 1'b1) begin
                if (q8.size() == 0) begin
                    check("done8_unexpected", 1, 0);
                end else begin
                    e = q8.pop_front();
                    check("score8", longint'(score8), longint'(e.score));
                    check("done8_cycle", longint'(cyc), longint'(e.due));
                end
            end
        end
    end

    task automatic go1(input logic [31:0] s, input int m, input logic [63:0] mk,
                       input int exp_score, output int acc);
        mode = m; emask = mk; seed1 = s; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        acc = cyc;
        q1.push_back('{exp_score, acc + 3});
    endtask

    task automatic go8(input logic [31:0] s, input int m, input logic [63:0] mk,
                       input int exp_score, input bit push, output int acc);
        mode = m; emask = mk; seed8 = s; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        acc = cyc;
        if (push) q8.push_back('{exp_score, acc + 24});
    endtask

    task automatic drain1();
        int n = 0;
        while (q1.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        if (q1.size() != 0) begin check("done1_timeout", 0, 1); q1.delete(); end
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        if (q8.size() != 0) begin check("done8_timeout", 0, 1); q8.delete(); end
    endtask

    initial begin
        int acc, seen, ex;
        logic [31:0] s;
        logic [63:0] mk;
        rst_n = 1'b0; mode = 0; emask = 64'h0;
        start1 = 1'b0; abort1 = 1'b0; seed1 = 32'h0;
        start8 = 1'b0; abort8 = 1'b0; seed8 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_score8", score8, 0);
        check("rst_ops8", {a1_8, a0_8, b1_8, b0_8}, 0);
        check("rst_busy1", busy1, 0);
        check("rst_score1", score1, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-round evaluations against the exhaustive pattern
        go1($urandom, 0, 64'h0, 64, acc);
        check("r0_a1", a1_1, 16'hFF00);
        check("r0_a0", a0_1, 16'hF0F0);
        check("r0_b1", b1_1, 16'hCCCC);
        check("r0_b0", b0_1, 16'hAAAA);
        drain1();
        check("score1_held", score1, 64);
        go1($urandom, 1, 64'h0, 50, acc);
        drain1();
        go1($urandom, 2, 64'h0, 14, acc);
        drain1();
        mk = {$urandom, $urandom};
        go1($urandom, 3, mk, model_score(32'h0, 1, 3, mk), acc);
        drain1();

        // Eight rounds, golden candidate, busy window
        go8(32'h0, 0, 64'h0, 512, 1'b1, acc);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            check("busy8_window", busy8, 1);
        end
        @(negedge clk);
        check("busy8_after", busy8, 0);
        drain8();
        check("score8_held", score8, 512);
        go8(32'hDEADBEEF, 0, 64'h0, 512, 1'b1, acc);
        drain8();

        // Faulty candidates with random seeds
        for (int i = 0; i < 6; i++) begin
            s  = $urandom;
            mk = {$urandom, $urandom};
            go8(s, 1 + (i % 3), mk, model_score(s, 8, 1 + (i % 3), mk), 1'b1, acc);
            drain8();
        end

        // Abort in CAPTURE of round 3
        s = $urandom; mk = {$urandom, $urandom};
        go8(s, 3, mk, 0, 1'b0, acc);
        while (cyc < acc + 10) begin @(posedge clk); #1; end
        abort8 = 1'b1;
        @(posedge clk); #1;
        abort8 = 1'b0;
        ex = model_score(s, 3, 3, mk);
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_partial", score8, ex);
        seen = 0;
        repeat (30) begin @(negedge clk); if (done8 === 1'b1) seen++; end
        check("abort_no_done", seen, 0);
        check("abort_score_hold", score8, ex);
        s = $urandom;
        go8(s, 3, mk, model_score(s, 8, 3, mk), 1'b1, acc);
        drain8();

        // start pulse while busy is ignored
        s = $urandom;
        go8(s, 2, 64'h0, model_score(s, 8, 2, 64'h0), 1'b1, acc);
        repeat (5) @(posedge clk);
        #1;
        seed8 = ~s; mode = 2; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        drain8();

        // Asynchronous reset during ACCUM of round 4
        go8($urandom, 0, 64'h0, 0, 1'b0, acc);
        while (cyc < acc + 14) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy8, 0);
        check("arst_done", done8, 0);
        check("arst_score", score8, 0);
        check("arst_ops", {a1_8, a0_8, b1_8, b0_8}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        s = $urandom;
        go8(s, 0, 64'h0, 512, 1'b1, acc);
        drain8();

        check("q1_empty", q1.size(), 0);
        check("q8_empty", q8.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
